// File: rtl/reg_hazard_scoreboard.sv
// Decode-stage register-use decoder plus in-flight destination scoreboard.
// Produces per-operand bypass selects, a decode stall and a busy-register mask.
module reg_hazard_scoreboard #(
   parameter int unsigned NREG     = 32,
   parameter int unsigned RW       = 5,
   parameter int unsigned DEPTH    = 3,
   parameter int unsigned LOAD_LAT = 2,
   parameter int unsigned FWD_EN   = 1,
   parameter int unsigned FW       = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            id_valid,
   input  logic [31:0]     id_instr,
   input  logic            id_wr_en,
   input  logic [RW-1:0]   id_wr_reg,
   input  logic            id_is_load,
   input  logic            advance,
   input  logic            flush,
   output logic            use_a,
   output logic            use_b,
   output logic [RW-1:0]   src_a,
   output logic [RW-1:0]   src_b,
   output logic [FW-1:0]   fwd_a,
   output logic [FW-1:0]   fwd_b,
   output logic            stall,
   output logic [NREG-1:0] busy_mask
);

   logic [5:0]    op, funct;
   logic [RW-1:0] rs, rt;
   logic          unused_instr_bits;

   // Entry k = 1 is EX, k = DEPTH is WB
   logic [DEPTH:1] ent_v;
   logic [DEPTH:1] ent_ld;
   logic [RW-1:0]  ent_reg [1:DEPTH];

   logic          hit_a, hit_b, ld_a, ld_b, chk_a, chk_b, hz_a, hz_b;
   logic [FW-1:0] idx_a, idx_b;

   assign op     = id_instr[31:26];
   assign funct  = id_instr[5:0];
   assign rs     = id_instr[25:21];
   assign rt     = id_instr[20:16];
   assign unused_instr_bits = ^id_instr[15:6];

   // Youngest valid entry targeting r: returns {hit, is_load, stage index}
   function automatic logic [FW+1:0] lookup(input logic [RW-1:0] r,
                                            input logic [DEPTH:1] v,
                                            input logic [DEPTH:1] ld,
                                            input logic [RW-1:0] regs [1:DEPTH]);
      logic [FW+1:0] res;
      res = '0;
      // Scan oldest to youngest so the smallest matching k is the one kept
      for (int unsigned k = DEPTH; k >= 1; k--) begin
         if (v[k] && regs[k] == r) res = {1'b1, ld[k], FW'(k)};
      end
      return res;
   endfunction

   // Source-field decode
   always_comb begin
      use_a = 1'b0;
      use_b = 1'b0;
      src_a = rs;
      src_b = rt;
      if (op == 6'b000000) begin
         case (funct)
            6'b100000, 6'b100001, 6'b100010, 6'b100100,
            6'b100101, 6'b100111, 6'b101010, 6'b101011: begin
               use_a = 1'b1;
               use_b = 1'b1;
            end
            6'b000000, 6'b000010, 6'b000011: use_b = 1'b1;
            6'b000100, 6'b000110, 6'b000111: begin
               use_a = 1'b1;
               use_b = 1'b1;
            end
            6'b001100: begin
               use_a = 1'b1;
               use_b = 1'b1;
               src_a = RW'(2);
               src_b = RW'(4);
            end
            default: ;
         endcase
      end else begin
         use_a = 1'b1;
         use_b = (op == 6'b000100) || (op == 6'b000101) || (op == 6'b101011);
      end
      if (!id_valid) begin
         use_a = 1'b0;
         use_b = 1'b0;
      end
   end

   // Hazard resolution per operand
   always_comb begin
      {hit_a, ld_a, idx_a} = lookup(src_a, ent_v, ent_ld, ent_reg);
      {hit_b, ld_b, idx_b} = lookup(src_b, ent_v, ent_ld, ent_reg);
      chk_a = use_a && (src_a != '0) && hit_a;
      chk_b = use_b && (src_b != '0) && hit_b;
      hz_a  = chk_a && !((FWD_EN != 0) && (!ld_a || 32'(idx_a) >= LOAD_LAT));
      hz_b  = chk_b && !((FWD_EN != 0) && (!ld_b || 32'(idx_b) >= LOAD_LAT));
      fwd_a = (chk_a && !hz_a) ? idx_a : '0;
      fwd_b = (chk_b && !hz_b) ? idx_b : '0;
      stall = (hz_a || hz_b) && id_valid && !flush;
   end

   // Busy mask from registered entries only
   always_comb begin
      busy_mask = '0;
      for (int unsigned k = 1; k <= DEPTH; k++) begin
         if (ent_v[k]) busy_mask[ent_reg[k]] = 1'b1;
      end
   end

   // Scoreboard shift pipeline; a stalled or flushed ID inserts a bubble
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent_v  <= '0;
         ent_ld <= '0;
         for (int unsigned k = 1; k <= DEPTH; k++) ent_reg[k] <= '0;
      end else if (advance) begin
         for (int unsigned k = 2; k <= DEPTH; k++) begin
            ent_v[k]   <= ent_v[k-1];
            ent_ld[k]  <= ent_ld[k-1];
            ent_reg[k] <= ent_reg[k-1];
         end
         ent_v[1]   <= id_valid && id_wr_en && (id_wr_reg != '0) && !stall && !flush;
         ent_ld[1]  <= id_is_load;
         ent_reg[1] <= id_wr_reg;
      end
   end

endmodule

// File: tb/tb_reg_hazard_scoreboard.sv
// Directed bench: decode vector table plus hand-written hazard sequences.
module tb_reg_hazard_scoreboard;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid;
   logic [31:0] id_instr;
   logic        id_wr_en;
   logic [4:0]  id_wr_reg;
   logic        id_is_load;
   logic        advance;
   logic        flush;

   logic        use_a, use_b, stall;
   logic [4:0]  src_a, src_b;
   logic [1:0]  fwd_a, fwd_b;
   logic [31:0] busy_mask;

   logic        x_use_a, x_use_b, x_stall;
   logic [4:0]  x_src_a, x_src_b;
   logic [1:0]  x_fwd_a, x_fwd_b;
   logic [31:0] x_busy_mask;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   reg_hazard_scoreboard #(.NREG(32), .RW(5), .DEPTH(3), .LOAD_LAT(2), .FWD_EN(1)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
      .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg), .id_is_load(id_is_load),
      .advance(advance), .flush(flush), .use_a(use_a), .use_b(use_b),
      .src_a(src_a), .src_b(src_b), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .stall(stall), .busy_mask(busy_mask));

   reg_hazard_scoreboard #(.NREG(32), .RW(5), .DEPTH(3), .LOAD_LAT(2), .FWD_EN(0)) dut_nofwd (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
      .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg), .id_is_load(id_is_load),
      .advance(advance), .flush(flush), .use_a(x_use_a), .use_b(x_use_b),
      .src_a(x_src_a), .src_b(x_src_b), .fwd_a(x_fwd_a), .fwd_b(x_fwd_b),
      .stall(x_stall), .busy_mask(x_busy_mask));

   typedef struct {
      logic        valid;
      logic [31:0] instr;
      logic        ua;
      logic        ub;
      logic [4:0]  sa;
      logic [4:0]  sb;
   } vec_t;

   vec_t vecs [12];

   function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
      return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt);
      return {op, 5'(rs), 5'(rt), 16'h0010};
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic we,
                        input int wr, input logic ld, input logic adv, input logic fl);
      id_valid   = v;
      id_instr   = ins;
      id_wr_en   = we;
      id_wr_reg  = 5'(wr);
      id_is_load = ld;
      advance    = adv;
      flush      = fl;
      #2;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 32'h0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
         step();
      end
   endtask

   initial begin
      vecs[0]  = '{1'b1, rtype(3, 1, 5, 6'b100000),  1'b1, 1'b1, 5'd3,  5'd1};
      vecs[1]  = '{1'b1, rtype(9, 7, 2, 6'b000000),  1'b0, 1'b1, 5'd0,  5'd7};
      vecs[2]  = '{1'b1, rtype(9, 9, 0, 6'b001100),  1'b1, 1'b1, 5'd2,  5'd4};
      vecs[3]  = '{1'b1, rtype(4, 6, 2, 6'b000100),  1'b1, 1'b1, 5'd4,  5'd6};
      vecs[4]  = '{1'b1, rtype(4, 6, 2, 6'b001000),  1'b0, 1'b0, 5'd0,  5'd0};
      vecs[5]  = '{1'b1, itype(6'b001000, 8, 9),     1'b1, 1'b0, 5'd8,  5'd0};
      vecs[6]  = '{1'b1, itype(6'b000100, 10, 11),   1'b1, 1'b1, 5'd10, 5'd11};
      vecs[7]  = '{1'b1, itype(6'b101011, 29, 12),   1'b1, 1'b1, 5'd29, 5'd12};
      vecs[8]  = '{1'b0, rtype(3, 1, 5, 6'b100000),  1'b0, 1'b0, 5'd0,  5'd0};
      vecs[9]  = '{1'b1, rtype(13, 14, 5, 6'b101010), 1'b1, 1'b1, 5'd13, 5'd14};
      vecs[10] = '{1'b1, rtype(0, 15, 5, 6'b000010), 1'b0, 1'b1, 5'd0,  5'd15};
      vecs[11] = '{1'b1, itype(6'b100011, 16, 17),   1'b1, 1'b0, 5'd16, 5'd0};

      rst_n = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      #20;
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Reset state with no valid instruction
      chk("reset_stall", int'(stall), 0);
      chk("reset_fwd_a", int'(fwd_a), 0);
      chk("reset_use_a", int'(use_a), 0);
      chk("reset_busy", int'(busy_mask), 0);

      // Decode table, scoreboard empty and held
      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].valid, vecs[i].instr, 1'b0, 0, 1'b0, 1'b0, 1'b0);
         chk($sformatf("dec%0d_use_a", i), int'(use_a), int'(vecs[i].ua));
         chk($sformatf("dec%0d_use_b", i), int'(use_b), int'(vecs[i].ub));
         if (vecs[i].ua) chk($sformatf("dec%0d_src_a", i), int'(src_a), int'(vecs[i].sa));
         if (vecs[i].ub) chk($sformatf("dec%0d_src_b", i), int'(src_b), int'(vecs[i].sb));
         chk($sformatf("dec%0d_stall", i), int'(stall), 0);
         step();
      end

      // 1) ALU forwarding from EX then MEM
      drive(1'b1, rtype(1, 2, 3, 6'b100000), 1'b1, 3, 1'b0, 1'b1, 1'b0);
      chk("t1_first_stall", int'(stall), 0);
      step();
      drive(1'b1, rtype(3, 1, 5, 6'b100000), 1'b1, 5, 1'b0, 1'b1, 1'b0);
      chk("t1_fwd_ex", int'(fwd_a), 1);
      chk("t1_stall_ex", int'(stall), 0);
      chk("t1_busy", int'(busy_mask), 32'h8);
      step();
      drive(1'b1, rtype(3, 0, 6, 6'b100000), 1'b0, 0, 1'b0, 1'b1, 1'b0);
      chk("t1_fwd_mem", int'(fwd_a), 2);
      chk("t1_fwd_b_zero", int'(fwd_b), 0);
      chk("t1_stall_mem", int'(stall), 0);
      step();
      drain();
      chk("t1_drained_busy", int'(busy_mask), 0);

      // 2) Load-use stalls one cycle, then forwards from stage 2
      drive(1'b1, itype(6'b100011, 1, 3), 1'b1, 3, 1'b1, 1'b1, 1'b0);
      step();
      drive(1'b1, rtype(3, 1, 5, 6'b100000), 1'b1, 5, 1'b0, 1'b1, 1'b0);
      chk("t2_stall", int'(stall), 1);
      chk("t2_fwd_during_stall", int'(fwd_a), 0);
      step();
      chk("t2_released", int'(stall), 0);
      chk("t2_fwd_ld", int'(fwd_a), 2);
      chk("t2_busy_bubble", int'(busy_mask), 32'h8);
      step();
      chk("t2_busy_after", int'(busy_mask), 32'h28);
      drain();

      // 3) No-forward variant stalls DEPTH cycles
      drive(1'b1, rtype(1, 2, 3, 6'b100000), 1'b1, 3, 1'b0, 1'b1, 1'b0);
      step();
      drive(1'b1, rtype(3, 1, 5, 6'b100000), 1'b1, 5, 1'b0, 1'b1, 1'b0);
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("t3_stall_c%0d", c), int'(x_stall), 1);
         step();
      end
      chk("t3_clear", int'(x_stall), 0);
      chk("t3_fwd_zero", int'(x_fwd_a), 0);
      step();
      drain();

      // 4) $0 is never tracked
      drive(1'b1, itype(6'b001000, 1, 0), 1'b1, 0, 1'b0, 1'b1, 1'b0);
      step();
      drive(1'b1, rtype(0, 0, 5, 6'b100000), 1'b0, 0, 1'b0, 1'b1, 1'b0);
      chk("t4_stall", int'(stall), 0);
      chk("t4_fwd_a", int'(fwd_a), 0);
      chk("t4_busy", int'(busy_mask), 0);
      step();
      drain();

      // 5) Two in-flight writers of $7: youngest wins
      drive(1'b1, rtype(1, 2, 7, 6'b100000), 1'b1, 7, 1'b0, 1'b1, 1'b0);
      step();
      drive(1'b1, rtype(1, 2, 7, 6'b100001), 1'b1, 7, 1'b0, 1'b1, 1'b0);
      step();
      drive(1'b1, rtype(7, 1, 8, 6'b100000), 1'b0, 0, 1'b0, 1'b1, 1'b0);
      chk("t5_youngest", int'(fwd_a), 1);
      chk("t5_busy", int'(busy_mask), 32'h80);
      step();
      drain();

      // 6) Flush overrides a load-use stall; bubble enters EX
      drive(1'b1, itype(6'b100011, 1, 4), 1'b1, 4, 1'b1, 1'b1, 1'b0);
      step();
      drive(1'b1, rtype(4, 1, 5, 6'b100000), 1'b1, 5, 1'b0, 1'b1, 1'b0);
      chk("t6_stall_pre", int'(stall), 1);
      flush = 1'b1;
      #1;
      chk("t6_flush_wins", int'(stall), 0);
      step();
      drive(1'b0, 32'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      chk("t6_busy_bubble", int'(busy_mask), 32'h10);
      drain();

      // 7) Asynchronous reset clears the scoreboard immediately
      drive(1'b1, rtype(1, 2, 9, 6'b100000), 1'b1, 9, 1'b0, 1'b1, 1'b0);
      step();
      drive(1'b0, 32'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      chk("t7_busy_before", int'(busy_mask), 32'h200);
      rst_n = 1'b0;
      #1;
      chk("t7_busy_async", int'(busy_mask), 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // advance=0 holds entries
      drive(1'b1, rtype(1, 2, 10, 6'b100000), 1'b1, 10, 1'b0, 1'b1, 1'b0);
      step();
      drive(1'b0, 32'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      step();
      step();
      chk("hold_busy", int'(busy_mask), 32'h400);
      drive(1'b1, rtype(10, 0, 11, 6'b100000), 1'b0, 0, 1'b0, 1'b0, 1'b0);
      chk("hold_fwd", int'(fwd_a), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
